voice_capture_buffer: RTL

Records the signed 8-bit voice sample stream into an on-chip sample RAM once the signal crosses an amplitude threshold. It is the writer end of the sample memory that the playback path reads from: samples go in through a valid strobe and are stored at consecutive addresses. A registered readback port lets the display and playback logic fetch stored samples. Capture is armed by a start pulse and stops when the buffer is full.

---
 rtl/voice_capture_buffer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/voice_capture_buffer.sv
// Threshold-triggered capture of a signed sample stream into a simple dual-port RAM,
// with a registered readback port for the display/playback side.
module voice_capture_buffer #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_sample,
  input  logic [DATA_W-1:0]   thresh,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                armed,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     wr_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   mag_c;
  logic                trig_c;
  logic                wr_en_c;
  logic [ADDR_W-1:0]   wr_addr_c;

  // |in_sample| kept unsigned at DATA_W bits, so the most negative code maps to 2**(DATA_W-1)
  always_comb begin
    mag_c = in_sample;
    if (in_sample[DATA_W-1]) begin
      mag_c = (~in_sample) + DATA_W'(1);
    end
  end

  // Write strobe: the trigger sample lands at 0, later samples at the running count
  always_comb begin
    trig_c    = 1'b0;
    wr_en_c   = 1'b0;
    wr_addr_c = wr_count[ADDR_W-1:0];
    if (!reset && in_valid) begin
      if (state == ARMED && mag_c >= thresh) begin
        trig_c    = 1'b1;
        wr_en_c   = 1'b1;
        wr_addr_c = '0;
      end else if (state == CAPTURE) begin
        wr_en_c = 1'b1;
      end
    end
  end

  // Capture control with registered status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      armed    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= ARMED;
            armed    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_count <= '0;
          end
        end
        ARMED: begin
          if (trig_c) begin
            state    <= CAPTURE;
            armed    <= 1'b0;
            busy     <= 1'b1;
            wr_count <= CNT_W'(1);
          end
        end
        CAPTURE: begin
          if (in_valid) begin
            wr_count <= wr_count + CNT_W'(1);
            if (wr_count == CNT_W'(DEPTH - 1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          armed <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Sample RAM write port; no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_addr_c] <= in_sample;
    end
  end

  // Registered read port; same-cycle write to the same address returns old data
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule
